jtag_debug_cmd_sync: RTL and testbench

Parametrised system-clock-side command receiver for the on-chip debug JTAG path; successor to the fixed 38-bit/2-bit-IR sysclk action decoder.
- Synchronises the virtual-JTAG update strobes (vs_udr, vs_uir) into clk.
- On each update, captures the shift register and IR, then queues the command in a FIFO of depth FIFO_DEPTH.
- Presents commands to the CPU debug logic over a valid/ready handshake, tagged take_action / take_no_action. Replaces the single-shot, no-backpressure pulse outputs.

---
 rtl/jtag_debug_pkg.sv | 27 ++
 rtl/jtag_debug_strobe_sync.sv | 30 +++
 rtl/jtag_debug_cmd_sync.sv | 146 ++++++++++++++
 tb/tb_jtag_debug_cmd_sync.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_debug_pkg.sv
// Shared widths, IR encodings and command record for the JTAG debug command path.
// Optional build macro JTAG_DBG_TIMESTAMP_EN adds a per-command timestamp field.
package jtag_debug_pkg;

  localparam int JDBG_DATA_W      = 38;
  localparam int JDBG_IR_W        = 2;
  localparam int JDBG_SYNC_STAGES = 2;
  localparam int JDBG_TS_W        = 16;

  typedef enum logic [JDBG_IR_W-1:0] {
    IR_OCIMEM    = 2'd0,
    IR_TRACEMEM  = 2'd1,
    IR_BREAK     = 2'd2,
    IR_TRACECTRL = 2'd3
  } jdbg_ir_e;

  // Default-width command record; the receiver keeps a parameter-width copy of the same layout.
  typedef struct packed {
    logic [JDBG_IR_W-1:0]   ir;
    logic [JDBG_DATA_W-1:0] data;
    logic                   action;
`ifdef JTAG_DBG_TIMESTAMP_EN
    logic [JDBG_TS_W-1:0]   ts;
`endif
  } jdbg_cmd_t;

endpackage

// File: rtl/jtag_debug_strobe_sync.sv
// Multi-flop synchroniser for an asynchronous level strobe with a registered
// rising-edge pulse (one pulse per low-to-high transition of the strobe).
module jtag_debug_strobe_sync
  import jtag_debug_pkg::*;
#(
  parameter int SYNC_STAGES = JDBG_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  // The history flop trails the last stage so a held strobe yields a single pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= '0;
      hist <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], strobe};
      hist <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~hist;
    end
  end

endmodule

// File: rtl/jtag_debug_cmd_sync.sv
// System-clock command receiver: synchronised JTAG update strobes feed a show-ahead
// command FIFO drained over valid/ready. Macro JTAG_DBG_TIMESTAMP_EN adds cmd_ts.
module jtag_debug_cmd_sync
  import jtag_debug_pkg::*;
#(
  parameter int DATA_W      = JDBG_DATA_W,
  parameter int IR_W        = JDBG_IR_W,
  parameter int SYNC_STAGES = JDBG_SYNC_STAGES,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACTION_BIT  = 35
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [IR_W-1:0]                 ir_in,
  input  logic [DATA_W-1:0]               sr,
  input  logic                            vs_udr,
  input  logic                            vs_uir,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [IR_W-1:0]                 cmd_ir,
  output logic [DATA_W-1:0]               cmd_data,
  output logic                            cmd_action,
  output logic                            uir_pulse,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  input  logic                            clr_overflow
`ifdef JTAG_DBG_TIMESTAMP_EN
  ,
  output logic [JDBG_TS_W-1:0]            cmd_ts
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [IR_W-1:0]      ir;
    logic [DATA_W-1:0]    data;
    logic                 action;
`ifdef JTAG_DBG_TIMESTAMP_EN
    logic [JDBG_TS_W-1:0] ts;
`endif
  } entry_t;

  entry_t            mem [FIFO_DEPTH];
  entry_t            wr_entry;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  held_level;
  logic              udr_rise;
  logic              uir_rise;
  logic              pop;
  logic              full;
  logic              push;
  logic              drop;

`ifdef JTAG_DBG_TIMESTAMP_EN
  logic [JDBG_TS_W-1:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + JDBG_TS_W'(1);
  end
`endif

  jtag_debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (vs_udr),
    .rise    (udr_rise)
  );

  jtag_debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (vs_uir),
    .rise    (uir_rise)
  );

  assign pop         = cmd_valid & cmd_ready;
  assign full        = (level == LVL_W'(FIFO_DEPTH));
  assign push        = udr_rise & (~full | pop);
  assign drop        = udr_rise & full & ~pop;
  // Entries already resident after this pop; a same-cycle push is not bypassed to the outputs.
  assign held_level  = level - LVL_W'(pop);
  assign rd_ptr_next = rd_ptr + PTR_W'(pop);
  assign fifo_level  = level;

  always_comb begin
    wr_entry        = '0;
    wr_entry.ir     = ir_in;
    wr_entry.data   = sr;
    wr_entry.action = sr[ACTION_BIT];
`ifdef JTAG_DBG_TIMESTAMP_EN
    wr_entry.ts     = ts_cnt;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      uir_pulse  <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_ir     <= '0;
      cmd_data   <= '0;
      cmd_action <= 1'b0;
`ifdef JTAG_DBG_TIMESTAMP_EN
      cmd_ts     <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_ptr_next;
      level     <= held_level + LVL_W'(push);
      uir_pulse <= uir_rise;
      if (clr_overflow) overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;

      cmd_valid <= (held_level != '0);
      if (held_level != '0) begin
        cmd_ir     <= mem[rd_ptr_next].ir;
        cmd_data   <= mem[rd_ptr_next].data;
        cmd_action <= mem[rd_ptr_next].action;
`ifdef JTAG_DBG_TIMESTAMP_EN
        cmd_ts     <= mem[rd_ptr_next].ts;
`endif
      end else begin
        cmd_ir     <= '0;
        cmd_data   <= '0;
        cmd_action <= 1'b0;
`ifdef JTAG_DBG_TIMESTAMP_EN
        cmd_ts     <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Self-checking bench for jtag_debug_cmd_sync: directed scenarios plus a randomized
// run compared against a transaction-level queue model of the command path.
module tb_jtag_debug_cmd_sync;

  localparam int S     = 2;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_udr;
  logic        vs_uir;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic        cmd_action;
  logic        uir_pulse;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        clr_overflow;
`ifdef JTAG_DBG_TIMESTAMP_EN
  logic [15:0] cmd_ts;
`endif

  int total;
  int passed;

  jtag_debug_cmd_sync #(
    .DATA_W(38), .IR_W(2), .SYNC_STAGES(S), .FIFO_DEPTH(DEPTH), .ACTION_BIT(35)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ir_in        (ir_in),
    .sr           (sr),
    .vs_udr       (vs_udr),
    .vs_uir       (vs_uir),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_ir       (cmd_ir),
    .cmd_data     (cmd_data),
    .cmd_action   (cmd_action),
    .uir_pulse    (uir_pulse),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef JTAG_DBG_TIMESTAMP_EN
    ,
    .cmd_ts       (cmd_ts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: an update first seen at edge N lands in the queue at
  // edge N+S+1, is visible one edge later, and uir pulses appear at edge N+S+1.
  typedef struct {
    logic [1:0]  ir;
    logic [37:0] data;
    logic        act;
    int          due;
  } ent_t;

  ent_t q[$];
  ent_t pend[$];
  int   uir_due[$];
  int   ecount = 0;
  logic m_prev_udr = 1'b0;
  logic m_prev_uir = 1'b0;
  logic m_valid = 1'b0;
  logic m_overflow = 1'b0;
  logic m_uir = 1'b0;

  always @(posedge clk) begin
    ent_t e;
    logic drop;
    ecount++;
    if (!reset_n) begin
      q.delete(); pend.delete(); uir_due.delete();
      m_prev_udr = 1'b0; m_prev_uir = 1'b0;
      m_valid = 1'b0; m_overflow = 1'b0; m_uir = 1'b0;
    end else begin
      if (m_valid && cmd_ready) void'(q.pop_front());
      m_uir = 1'b0;
      if (uir_due.size() > 0 && uir_due[0] == ecount) begin
        m_uir = 1'b1;
        void'(uir_due.pop_front());
      end
      if (vs_udr && !m_prev_udr) begin
        e.ir = ir_in; e.data = sr; e.act = sr[35]; e.due = ecount + S + 1;
        pend.push_back(e);
      end
      if (vs_uir && !m_prev_uir) uir_due.push_back(ecount + S + 1);
      m_prev_udr = vs_udr;
      m_prev_uir = vs_uir;
      drop = 1'b0;
      if (pend.size() > 0 && pend[0].due == ecount) begin
        e = pend.pop_front();
        if (q.size() == DEPTH) drop = 1'b1;
        else begin
          e.due = ecount + 1;
          q.push_back(e);
        end
      end
      if (clr_overflow) m_overflow = 1'b0;
      else if (drop)    m_overflow = 1'b1;
      m_valid = (q.size() > 0) && (q[0].due <= ecount);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fire_udr(input logic [1:0] ir, input logic [37:0] d);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    step(S + 3);
    vs_udr = 1'b0;
    step(S + 2);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(2);
    total++; if (cmd_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", cmd_valid); else passed++;
    total++; if (fifo_level !== 3'd0) $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); else passed++;
    total++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); else passed++;
    total++; if (uir_pulse !== 1'b0) $display("[TB] FAIL reset_uir: got %b expected 0", uir_pulse); else passed++;
    total++; if (cmd_data !== 38'd0) $display("[TB] FAIL reset_data: got %h expected 0", cmd_data); else passed++;
    total++; if (cmd_ir !== 2'd0) $display("[TB] FAIL reset_ir: got %0d expected 0", cmd_ir); else passed++;
    total++; if (cmd_action !== 1'b0) $display("[TB] FAIL reset_action: got %b expected 0", cmd_action); else passed++;
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_single_capture;
    ir_in = 2'b10; sr = 38'h20_0000_00AB; vs_udr = 1'b1;
    step(S + 1);
    step(1);
    total++; if (cmd_valid !== 1'b0) $display("[TB] FAIL lat_early_valid: got %b expected 0", cmd_valid); else passed++;
    total++; if (fifo_level !== 3'd1) $display("[TB] FAIL lat_write_level: got %0d expected 1", fifo_level); else passed++;
    step(1);
    total++; if (cmd_valid !== 1'b1) $display("[TB] FAIL lat_valid: got %b expected 1", cmd_valid); else passed++;
    total++; if (cmd_ir !== 2'd2) $display("[TB] FAIL cap_ir: got %0d expected 2", cmd_ir); else passed++;
    total++; if (cmd_data !== 38'h20_0000_00AB) $display("[TB] FAIL cap_data: got %h expected 20000000ab", cmd_data); else passed++;
    total++; if (cmd_action !== 1'b0) $display("[TB] FAIL cap_action: got %b expected 0", cmd_action); else passed++;
    vs_udr = 1'b0;
    step(S + 2);
    cmd_ready = 1'b1; step(1); cmd_ready = 1'b0;
    total++; if (cmd_valid !== 1'b0 || fifo_level !== 3'd0) $display("[TB] FAIL cap_pop: got valid %b level %0d expected valid 0 level 0", cmd_valid, fifo_level); else passed++;
  endtask

  task automatic fill_four;
    logic [37:0] d;
    for (int k = 1; k <= 4; k++) begin
      d = 38'(k); d[35] = 1'b1;
      fire_udr(2'd1, d);
    end
  endtask

  task automatic test_queue_drain;
    logic [37:0] d;
    cmd_ready = 1'b0;
    fill_four();
    total++; if (fifo_level !== 3'd4) $display("[TB] FAIL fill_level: got %0d expected 4", fifo_level); else passed++;
    total++; if (cmd_action !== 1'b1) $display("[TB] FAIL fill_action: got %b expected 1", cmd_action); else passed++;
    cmd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      d = 38'(k); d[35] = 1'b1;
      total++; if (cmd_valid !== 1'b1 || cmd_data !== d) $display("[TB] FAIL drain_%0d: got valid %b data %h expected valid 1 data %h", k, cmd_valid, cmd_data, d); else passed++;
      step(1);
    end
    cmd_ready = 1'b0;
    total++; if (cmd_valid !== 1'b0 || fifo_level !== 3'd0) $display("[TB] FAIL drain_empty: got valid %b level %0d expected valid 0 level 0", cmd_valid, fifo_level); else passed++;
  endtask

  task automatic test_overflow_drop;
    logic [37:0] d;
    fill_four();
    d = 38'd5; d[35] = 1'b1;
    fire_udr(2'd1, d);
    total++; if (overflow !== 1'b1) $display("[TB] FAIL drop_overflow: got %b expected 1", overflow); else passed++;
    total++; if (fifo_level !== 3'd4) $display("[TB] FAIL drop_level: got %0d expected 4", fifo_level); else passed++;
    clr_overflow = 1'b1; step(1); clr_overflow = 1'b0;
    total++; if (overflow !== 1'b0) $display("[TB] FAIL clr_overflow: got %b expected 0", overflow); else passed++;
    cmd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      d = 38'(k); d[35] = 1'b1;
      total++; if (cmd_data !== d) $display("[TB] FAIL drop_order_%0d: got %h expected %h", k, cmd_data, d); else passed++;
      step(1);
    end
    cmd_ready = 1'b0;
    step(1);
  endtask

  task automatic test_full_pop_push;
    logic [37:0] d;
    fill_four();
    d = 38'd5; d[35] = 1'b1;
    ir_in = 2'd1; sr = d; vs_udr = 1'b1;
    step(S + 1);
    cmd_ready = 1'b1; step(1); cmd_ready = 1'b0;
    total++; if (fifo_level !== 3'd4) $display("[TB] FAIL popush_level: got %0d expected 4", fifo_level); else passed++;
    total++; if (overflow !== 1'b0) $display("[TB] FAIL popush_overflow: got %b expected 0", overflow); else passed++;
    step(1);
    vs_udr = 1'b0;
    step(S + 2);
    cmd_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      d = 38'(k); d[35] = 1'b1;
      total++; if (cmd_valid !== 1'b1 || cmd_data !== d) $display("[TB] FAIL popush_order_%0d: got valid %b data %h expected valid 1 data %h", k, cmd_valid, cmd_data, d); else passed++;
      step(1);
    end
    cmd_ready = 1'b0;
    step(1);
  endtask

  task automatic test_uir;
    int pulses;
    fire_udr(2'd1, 38'h12345);
    pulses = 0;
    vs_uir = 1'b1;
    repeat (10) begin step(1); pulses += int'(uir_pulse); end
    vs_uir = 1'b0;
    repeat (S + 4) begin step(1); pulses += int'(uir_pulse); end
    total++; if (pulses != 1) $display("[TB] FAIL uir_count: got %0d expected 1", pulses); else passed++;
    total++; if (fifo_level !== 3'd1 || cmd_data !== 38'h12345) $display("[TB] FAIL uir_fifo: got level %0d data %h expected level 1 data 12345", fifo_level, cmd_data); else passed++;
    cmd_ready = 1'b1; step(1); cmd_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) fire_udr(2'(k), 38'(k + 10));
    reset_n = 1'b0; step(1); reset_n = 1'b1;
    total++; if (cmd_valid !== 1'b0 || fifo_level !== 3'd0) $display("[TB] FAIL midreset: got valid %b level %0d expected valid 0 level 0", cmd_valid, fifo_level); else passed++;
    fire_udr(2'd3, 38'h3F_FFFF_FFFF);
    total++; if (cmd_valid !== 1'b1 || cmd_ir !== 2'd3 || cmd_data !== 38'h3F_FFFF_FFFF || cmd_action !== 1'b1 || fifo_level !== 3'd1)
      $display("[TB] FAIL postreset_cmd: got valid %b ir %0d data %h act %b level %0d expected 1 3 3fffffffff 1 1", cmd_valid, cmd_ir, cmd_data, cmd_action, fifo_level);
    else passed++;
    cmd_ready = 1'b1; step(1); cmd_ready = 1'b0;
  endtask

  task automatic test_random;
    int udr_hi, udr_lo, uir_hi, uir_lo;
    logic [1:0]  e_ir;
    logic [37:0] e_data;
    logic        e_act;
    udr_hi = 0; udr_lo = 0; uir_hi = 0; uir_lo = 0;
    for (int c = 0; c < 600; c++) begin
      e_ir   = m_valid ? q[0].ir   : 2'd0;
      e_data = m_valid ? q[0].data : 38'd0;
      e_act  = m_valid ? q[0].act  : 1'b0;
      total++; if (cmd_valid !== m_valid) $display("[TB] FAIL rand_valid@%0d: got %b expected %b", c, cmd_valid, m_valid); else passed++;
      total++; if (cmd_ir !== e_ir) $display("[TB] FAIL rand_ir@%0d: got %0d expected %0d", c, cmd_ir, e_ir); else passed++;
      total++; if (cmd_data !== e_data) $display("[TB] FAIL rand_data@%0d: got %h expected %h", c, cmd_data, e_data); else passed++;
      total++; if (cmd_action !== e_act) $display("[TB] FAIL rand_action@%0d: got %b expected %b", c, cmd_action, e_act); else passed++;
      total++; if (fifo_level !== 3'(q.size())) $display("[TB] FAIL rand_level@%0d: got %0d expected %0d", c, fifo_level, q.size()); else passed++;
      total++; if (overflow !== m_overflow) $display("[TB] FAIL rand_overflow@%0d: got %b expected %b", c, overflow, m_overflow); else passed++;
      total++; if (uir_pulse !== m_uir) $display("[TB] FAIL rand_uir@%0d: got %b expected %b", c, uir_pulse, m_uir); else passed++;

      if (vs_udr) begin
        udr_hi--;
        if (udr_hi == 0) begin vs_udr = 1'b0; udr_lo = $urandom_range(S + 2, S + 6); end
      end else if (udr_lo > 0) udr_lo--;
      else if ($urandom_range(0, 2) == 0) begin
        vs_udr = 1'b1; udr_hi = $urandom_range(S + 3, S + 5);
        ir_in = 2'($urandom); sr = {6'($urandom), $urandom};
      end
      if (vs_uir) begin
        uir_hi--;
        if (uir_hi == 0) begin vs_uir = 1'b0; uir_lo = $urandom_range(1, 8); end
      end else if (uir_lo > 0) uir_lo--;
      else if ($urandom_range(0, 3) == 0) begin vs_uir = 1'b1; uir_hi = $urandom_range(1, 10); end
      cmd_ready    = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      reset_n      = ($urandom_range(0, 249) != 0);
      step(1);
    end
    reset_n = 1'b1; cmd_ready = 1'b0; clr_overflow = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0;
    reset_n = 1'b0; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0;
    cmd_ready = 1'b0; clr_overflow = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_capture();
    test_queue_drain();
    test_overflow_drop();
    test_full_pop_push();
    test_uir();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got still running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
